phys_free_list: RTL and testbench
=================================

PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS, 64, number of physical registers.
REQ-002 SHALL have parameter NUM_ARCH, 32, number of architectural registers; DEPTH = NUM_PHYS-NUM_ARCH = 32 list entries.
REQ-003 SHALL have parameter PW, 6, physical register tag width.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  reset, asynchronous, active-low.
REQ-006 alloc_req  input  1  rename requests one destination tag this cycle.
REQ-007 alloc_ready  output  1  a free tag is available (combinational from registered state).
REQ-008 alloc_reg  output  PW  tag at list head, valid when alloc_ready.
REQ-009 commit_valid  input  1  oldest speculative allocation retires.
REQ-010 release_valid  input  1  retirement returns a previous mapping to the list.
REQ-011 release_reg  input  PW  tag being returned.
REQ-012 flush  input  1  discard all speculative (uncommitted) allocations.
REQ-013 free_count  output  PW  number of tags currently allocatable (0..DEPTH).
REQ-014 spec_count  output  PW  number of allocated but uncommitted tags.
REQ-015 error  output  1  sticky protocol-violation flag.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with three pointers of log2(DEPTH)+1 bits (extra wrap bit): head (alloc), rhead (committed head), tail (release).
REQ-017 free_count SHALL equal tail-head and spec_count SHALL equal head-rhead, computed modulo 2^(log2(DEPTH)+1).
REQ-018 alloc_ready SHALL be 1 iff free_count != 0 and flush == 0; alloc_reg SHALL be entry[head[4:0]].
REQ-019 An allocation SHALL fire when alloc_req && alloc_ready; head increments by 1 next edge; at most one allocation per cycle.
REQ-020 alloc_req while free_count == 0 SHALL be ignored without error (rename stalls); a release in the same cycle SHALL NOT be bypassed to alloc_reg.
REQ-021 commit_valid SHALL increment rhead when spec_count != 0; when spec_count == 0 it SHALL be ignored and set error.
REQ-022 release_valid SHALL write release_reg to entry[tail[4:0]] and increment tail when free_count != DEPTH and release_reg >= NUM_ARCH-relative range check passes (release_reg != 0).
REQ-023 release_valid with free_count == DEPTH SHALL be dropped and set error; release_reg == 0 SHALL be dropped silently (physical r0 is never freed).
REQ-024 flush SHALL set head <= rhead(next), i.e. rhead after any same-cycle commit; a same-cycle alloc_req SHALL NOT fire.
REQ-025 release and commit in the flush cycle SHALL still take effect (both are non-speculative).
REQ-026 Simultaneous alloc, commit and release without flush SHALL all take effect in the same edge.
REQ-027 Pointer wrap from 63 to 0 (6-bit) SHALL preserve count arithmetic; entries are indexed by low 5 bits.
REQ-028 error SHALL remain 1 until RESET once set.

Reset
REQ-029 On RESET low, entry[i] SHALL load NUM_ARCH+i for i = 0..DEPTH-1 (tags 32..63).
REQ-030 On RESET low, head = rhead = 0, tail = DEPTH (32), error = 0; hence free_count = 32, spec_count = 0, alloc_ready = 1, alloc_reg = 32.
REQ-031 RESET asserted mid-operation SHALL discard all in-flight state immediately, independent of CLK.

Verification
REQ-032 After reset, alloc_req for 3 cycles -> alloc_reg 32,33,34; free_count 29; spec_count 3.
REQ-033 Allocate 32 consecutive cycles -> free_count 0, alloc_ready 0; 33rd alloc_req ignored, error stays 0; then release_valid reg 40 -> next cycle alloc_ready 1, alloc_reg 40.
REQ-034 Allocate 5 (32..36), commit 2, flush -> head = 2, spec_count 0, free_count 30, alloc_reg 34.
REQ-035 Flush with alloc_req, commit_valid and release_valid(reg 5) in same cycle -> no allocation, rhead+1, head = new rhead, tag 5 appended at tail.
REQ-036 Release at free_count 32 -> dropped, error 1 sticky; commit with spec_count 0 -> error 1; release_reg 0 -> dropped, error unchanged.
REQ-037 Run 200 cycles of random alloc/commit/release keeping tags unique, plus wrap past pointer 63 -> free_count+spec_count+committed mappings always 64, no tag duplicated.

Source files
------------

// File: rtl/phys_free_list_if.sv
// Handshake bundle between the rename stage and the physical register free list.
// master: rename/retire side that requests tags and returns them.
// slave:  the free list itself.
interface phys_free_list_if #(
  parameter int PW = 6
);
  logic          alloc_req;
  logic          alloc_ready;
  logic [PW-1:0] alloc_reg;
  logic          commit_valid;
  logic          release_valid;
  logic [PW-1:0] release_reg;
  logic          flush;
  logic [PW-1:0] free_count;
  logic [PW-1:0] spec_count;
  logic          error;

  modport master (
    output alloc_req,
    output commit_valid,
    output release_valid,
    output release_reg,
    output flush,
    input  alloc_ready,
    input  alloc_reg,
    input  free_count,
    input  spec_count,
    input  error
  );

  modport slave (
    input  alloc_req,
    input  commit_valid,
    input  release_valid,
    input  release_reg,
    input  flush,
    output alloc_ready,
    output alloc_reg,
    output free_count,
    output spec_count,
    output error
  );
endinterface

// File: rtl/phys_free_list.sv
// Physical register free list for register renaming.
// Circular buffer of free tags with three wrap-bit pointers:
//   head  - next tag handed to rename (speculative allocation point)
//   rhead - oldest uncommitted allocation; flush rewinds head back here
//   tail  - where retired (previous-mapping) tags are returned
// [rhead, head) are speculatively allocated tags, [head, tail) are free.
// Because flush only moves head, speculative tags reappear at the list head
// in their original order after a flush.
module phys_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int PW       = 6
) (
  input  logic           CLK,
  input  logic           RESET,
  phys_free_list_if.slave bus
);

  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = '0;
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);
  localparam logic [PW-1:0]    TAG_ZERO  = '0;

  logic [PW-1:0]    entry [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] rhead;
  logic [PTR_W-1:0] tail;
  logic             err_q;

  logic [PTR_W-1:0] free_cnt;
  logic [PTR_W-1:0] spec_cnt;
  logic [PTR_W-1:0] rhead_nxt;
  logic [PTR_W-1:0] head_nxt;
  logic             alloc_fire;
  logic             commit_fire;
  logic             release_fire;
  logic             release_nz;
  logic             list_full;
  logic             err_set;

  // Occupancy, handshake decisions and next-pointer values from registered state.
  always_comb begin
    free_cnt     = tail - head;
    spec_cnt     = head - rhead;
    list_full    = (free_cnt == PTR_DEPTH);
    release_nz   = (bus.release_reg != TAG_ZERO);

    bus.alloc_ready = (free_cnt != PTR_ZERO) && !bus.flush;
    bus.alloc_reg   = entry[head[AW-1:0]];
    bus.free_count  = PW'(free_cnt);
    bus.spec_count  = PW'(spec_cnt);
    bus.error       = err_q;

    alloc_fire   = bus.alloc_req && bus.alloc_ready;
    commit_fire  = bus.commit_valid && (spec_cnt != PTR_ZERO);
    // Tag 0 is the hardwired zero register and never enters the list.
    release_fire = bus.release_valid && release_nz && !list_full;
    err_set      = (bus.commit_valid && (spec_cnt == PTR_ZERO)) ||
                   (bus.release_valid && release_nz && list_full);

    rhead_nxt = commit_fire ? (rhead + PTR_ONE) : rhead;
    // Flush rewinds to the committed head including this cycle's commit.
    if (bus.flush) begin
      head_nxt = rhead_nxt;
    end else if (alloc_fire) begin
      head_nxt = head + PTR_ONE;
    end else begin
      head_nxt = head;
    end
  end

  // Pointer and sticky error registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head  <= PTR_ZERO;
      rhead <= PTR_ZERO;
      tail  <= PTR_DEPTH;
      err_q <= 1'b0;
    end else begin
      head  <= head_nxt;
      rhead <= rhead_nxt;
      if (release_fire) begin
        tail <= tail + PTR_ONE;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage: preloaded with the non-architectural tags, written at tail on release.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PW'(NUM_ARCH + i);
      end
    end else if (release_fire) begin
      entry[tail[AW-1:0]] <= bus.release_reg;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list. The model keeps explicit tag queues:
// free_q (expected allocation order), spec_q (uncommitted allocations) and
// map_q (committed mappings other than r0).
module tb_phys_free_list;

  localparam int DEPTH = 32;

  logic CLK;
  logic RESET;

  phys_free_list_if #(.PW(6)) bus ();

  phys_free_list #(
    .NUM_PHYS(64),
    .NUM_ARCH(32),
    .PW(6)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int n_tests;
  int n_fail;

  int free_q[$];
  int spec_q[$];
  int map_q[$];
  bit m_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.alloc_req     = 1'b0;
    bus.commit_valid  = 1'b0;
    bus.release_valid = 1'b0;
    bus.release_reg   = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic model_reset();
    free_q.delete();
    spec_q.delete();
    map_q.delete();
    for (int i = 0; i < DEPTH; i++) free_q.push_back(32 + i);
    for (int i = 1; i < 32; i++) map_q.push_back(i);
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge CLK);
    RESET = 1'b0;
    #3;
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
  endtask

  // Drive one cycle of stimulus, update the model at the edge. Returns the
  // DUT's presented tag, whether the model expects an allocation, and the
  // tag popped from the expected-allocation queue.
  task automatic step(input bit a, input bit c, input bit r, input int rreg,
                      input bit f, output bit fired, output int got, output int exp);
    int f0, s0;
    @(negedge CLK);
    bus.alloc_req     = a;
    bus.commit_valid  = c;
    bus.release_valid = r;
    bus.release_reg   = 6'(rreg);
    bus.flush         = f;
    #1;
    got   = int'(bus.alloc_reg);
    fired = a && !f && (free_q.size() != 0);
    exp   = -1;
    @(posedge CLK);
    f0 = free_q.size();
    s0 = spec_q.size();
    if (c) begin
      if (s0 != 0) map_q.push_back(spec_q.pop_front());
      else m_err = 1'b1;
    end
    if (fired) begin
      exp = free_q.pop_front();
      spec_q.push_back(exp);
    end
    if (f) begin
      while (spec_q.size() != 0) free_q.push_front(spec_q.pop_back());
    end
    if (r && rreg != 0) begin
      if (f0 == DEPTH) begin
        m_err = 1'b1;
      end else begin
        free_q.push_back(rreg);
        for (int i = 0; i < map_q.size(); i++) begin
          if (map_q[i] == rreg) begin
            map_q.delete(i);
            break;
          end
        end
      end
    end
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (int'(bus.free_count) !== 32) begin n_fail++; $display("FAIL reset_free_count: got %0d expected 32", bus.free_count); end
    n_tests++;
    if (int'(bus.spec_count) !== 0) begin n_fail++; $display("FAIL reset_spec_count: got %0d expected 0", bus.spec_count); end
    n_tests++;
    if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b expected 1", bus.alloc_ready); end
    n_tests++;
    if (int'(bus.alloc_reg) !== 32) begin n_fail++; $display("FAIL reset_alloc_reg: got %0d expected 32", bus.alloc_reg); end
    n_tests++;
    if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", bus.error); end
  endtask

  task automatic test_alloc3();
    bit fired; int got, exp;
    int want[3] = '{32, 33, 34};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, fired, got, exp);
      n_tests++;
      if (!fired || got !== exp || got !== want[i]) begin
        n_fail++; $display("FAIL alloc3_tag[%0d]: got %0d expected %0d", i, got, want[i]);
      end
    end
    n_tests++;
    if (int'(bus.free_count) !== 29) begin n_fail++; $display("FAIL alloc3_free_count: got %0d expected 29", bus.free_count); end
    n_tests++;
    if (int'(bus.spec_count) !== 3) begin n_fail++; $display("FAIL alloc3_spec_count: got %0d expected 3", bus.spec_count); end
  endtask

  task automatic test_full();
    bit fired; int got, exp;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, fired, got, exp);
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL full_tag[%0d]: got %0d expected %0d", i, got, exp); end
    end
    n_tests++;
    if (int'(bus.free_count) !== 0) begin n_fail++; $display("FAIL full_free_count: got %0d expected 0", bus.free_count); end
    n_tests++;
    if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_alloc_ready: got %b expected 0", bus.alloc_ready); end
    step(1, 0, 0, 0, 0, fired, got, exp);
    n_tests++;
    if (int'(bus.free_count) !== 0 || int'(bus.spec_count) !== 32) begin
      n_fail++; $display("FAIL full_stall_counts: got free %0d spec %0d expected free 0 spec 32", bus.free_count, bus.spec_count);
    end
    n_tests++;
    if (bus.error !== 1'b0) begin n_fail++; $display("FAIL full_stall_error: got %b expected 0", bus.error); end
    step(0, 0, 1, 40, 0, fired, got, exp);
    n_tests++;
    if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL full_release_ready: got %b expected 1", bus.alloc_ready); end
    n_tests++;
    if (int'(bus.alloc_reg) !== 40 || free_q[0] !== 40) begin n_fail++; $display("FAIL full_release_reg: got %0d expected 40", bus.alloc_reg); end
  endtask

  task automatic test_flush();
    bit fired; int got, exp;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, fired, got, exp);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, fired, got, exp);
    step(0, 0, 0, 0, 1, fired, got, exp);
    n_tests++;
    if (int'(bus.spec_count) !== 0) begin n_fail++; $display("FAIL flush_spec_count: got %0d expected 0", bus.spec_count); end
    n_tests++;
    if (int'(bus.free_count) !== 30) begin n_fail++; $display("FAIL flush_free_count: got %0d expected 30", bus.free_count); end
    n_tests++;
    if (int'(bus.alloc_reg) !== 34 || free_q[0] !== 34) begin n_fail++; $display("FAIL flush_alloc_reg: got %0d expected 34", bus.alloc_reg); end
  endtask

  task automatic test_flush_combo();
    bit fired; int got, exp;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, fired, got, exp);
    step(1, 1, 1, 5, 1, fired, got, exp);
    n_tests++;
    if (int'(bus.spec_count) !== 0 || int'(bus.free_count) !== 32) begin
      n_fail++; $display("FAIL combo_counts: got free %0d spec %0d expected free 32 spec 0", bus.free_count, bus.spec_count);
    end
    n_tests++;
    if (int'(bus.alloc_reg) !== 33) begin n_fail++; $display("FAIL combo_alloc_reg: got %0d expected 33", bus.alloc_reg); end
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, fired, got, exp);
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL combo_drain[%0d]: got %0d expected %0d", i, got, exp); end
    end
    n_tests++;
    if (got !== 5) begin n_fail++; $display("FAIL combo_tail_tag: got %0d expected 5", got); end
    n_tests++;
    if (bus.error !== 1'b0) begin n_fail++; $display("FAIL combo_error: got %b expected 0", bus.error); end
  endtask

  task automatic test_errors();
    bit fired; int got, exp;
    do_reset();
    step(0, 0, 1, 50, 0, fired, got, exp);
    n_tests++;
    if (bus.error !== 1'b1 || int'(bus.free_count) !== 32) begin
      n_fail++; $display("FAIL err_release_full: got error %b free %0d expected error 1 free 32", bus.error, bus.free_count);
    end
    step(1, 0, 0, 0, 0, fired, got, exp);
    step(0, 1, 0, 0, 0, fired, got, exp);
    n_tests++;
    if (bus.error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.error); end
    do_reset();
    step(0, 1, 0, 0, 0, fired, got, exp);
    n_tests++;
    if (bus.error !== m_err || bus.error !== 1'b1) begin n_fail++; $display("FAIL err_commit_empty: got %b expected 1", bus.error); end
    do_reset();
    step(1, 0, 0, 0, 0, fired, got, exp);
    step(0, 0, 1, 0, 0, fired, got, exp);
    n_tests++;
    if (bus.error !== 1'b0 || int'(bus.free_count) !== 31) begin
      n_fail++; $display("FAIL err_release_r0: got error %b free %0d expected error 0 free 31", bus.error, bus.free_count);
    end
  endtask

  task automatic test_async_reset();
    bit fired; int got, exp;
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, fired, got, exp);
    step(0, 1, 0, 0, 0, fired, got, exp);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    n_tests++;
    if (int'(bus.free_count) !== 32 || int'(bus.spec_count) !== 0 || int'(bus.alloc_reg) !== 32 || bus.error !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got free %0d spec %0d reg %0d err %b expected 32 0 32 0",
                         bus.free_count, bus.spec_count, bus.alloc_reg, bus.error);
    end
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_random();
    bit fired; int got, exp;
    bit a, c, r, f;
    int rreg, occ, releases;
    do_reset();
    releases = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      a = ($urandom_range(0, 99) < 60);
      c = (spec_q.size() != 0) && ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 99) < 4);
      r = 1'b0;
      rreg = 0;
      if ((map_q.size() + 1 + (c ? 1 : 0) > 32) && ($urandom_range(0, 99) < 85)) begin
        r = 1'b1;
        rreg = map_q[$urandom_range(0, map_q.size() - 1)];
        releases++;
      end
      step(a, c, r, rreg, f, fired, got, exp);
      if (fired) begin
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL rand_tag[%0d]: got %0d expected %0d", cyc, got, exp); end
        occ = 0;
        foreach (free_q[i]) if (free_q[i] == got) occ++;
        foreach (spec_q[i]) if (spec_q[i] == got) occ++;
        foreach (map_q[i])  if (map_q[i] == got) occ++;
        n_tests++;
        if (occ !== 1) begin n_fail++; $display("FAIL rand_unique[%0d]: tag %0d seen %0d times expected 1", cyc, got, occ); end
      end
      n_tests++;
      if (int'(bus.free_count) !== free_q.size() || int'(bus.spec_count) !== spec_q.size()) begin
        n_fail++; $display("FAIL rand_counts[%0d]: got free %0d spec %0d expected free %0d spec %0d",
                           cyc, bus.free_count, bus.spec_count, free_q.size(), spec_q.size());
      end
      n_tests++;
      if (int'(bus.free_count) + int'(bus.spec_count) + map_q.size() + 1 !== 64) begin
        n_fail++; $display("FAIL rand_total[%0d]: got %0d expected 64", cyc,
                           int'(bus.free_count) + int'(bus.spec_count) + map_q.size() + 1);
      end
    end
    n_tests++;
    if (bus.error !== 1'b0) begin n_fail++; $display("FAIL rand_error: got %b expected 0", bus.error); end
    // More than 32 releases carry the tail pointer past 63 and back through 0.
    for (int k = 0; k < 40 && releases <= 40; k++) begin
      if (spec_q.size() == 0) step(1, 0, 0, 0, 0, fired, got, exp);
      step(1, 1, 1, map_q[0], 0, fired, got, exp);
      releases++;
      n_tests++;
      if (int'(bus.free_count) !== free_q.size() || int'(bus.spec_count) !== spec_q.size()) begin
        n_fail++; $display("FAIL wrap_counts[%0d]: got free %0d spec %0d expected free %0d spec %0d",
                           k, bus.free_count, bus.spec_count, free_q.size(), spec_q.size());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET   = 1'b1;
    clear_inputs();
    test_reset();
    test_alloc3();
    test_full();
    test_flush();
    test_flush_combo();
    test_errors();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
